// File: rtl/nzr_pixel_rx.sv
// WS2812B NZR receiver: decodes 24-bit GRB words, detects frame gaps and timeouts.
// Optional pixel mode (macro NZR_FORWARD_EN): keep the first word of each frame and forward the rest on dataOut.
module nzr_pixel_rx #(
    parameter int BIT_THRESH   = 30,
    parameter int MAX_HIGH     = 75,
    parameter int RESET_CYCLES = 2500
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        dataIn,
    output logic [23:0] grb,
    output logic        grbValid,
    output logic        frameDone,
    output logic [7:0]  wordCount,
    output logic        error,
    output logic        dataOut,
    output logic [1:0]  fsm_state
);
    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        HIGH     = 2'd1,
        LOW      = 2'd2,
        WAIT_GAP = 2'd3
    } state_t;

    localparam logic [16:0] BIT_MIN   = 17'(BIT_THRESH);
    localparam logic [15:0] HIGH_LAST = 16'(MAX_HIGH - 1);
    localparam logic [15:0] GAP_LAST  = 16'(RESET_CYCLES - 1);

    state_t      state;
    logic        sync_meta;
    logic        sync;
    logic        sync_d;
    logic [15:0] cnt;
    logic [23:0] shreg;
    logic [4:0]  bit_cnt;

    logic        rise;
    logic        fall;
    logic [16:0] high_len;
    logic        bit_val;
    logic [23:0] next_word;
    logic [15:0] cnt_inc;
    logic [7:0]  wc_inc;

    assign rise      = sync & ~sync_d;
    assign fall      = ~sync & sync_d;
    // cnt counts high samples after the rising-edge sample, so add that one back
    assign high_len  = {1'b0, cnt} + 17'd1;
    assign bit_val   = (high_len >= BIT_MIN);
    assign next_word = {shreg[22:0], bit_val};
    assign cnt_inc   = (cnt == 16'hFFFF) ? cnt : cnt + 16'd1;
    assign wc_inc    = (wordCount == 8'hFF) ? wordCount : wordCount + 8'd1;
    assign fsm_state = state;

`ifdef NZR_FORWARD_EN
    logic fwd;
`else
    assign dataOut = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= WAIT_GAP;
            sync_meta <= 1'b0;
            sync      <= 1'b0;
            sync_d    <= 1'b0;
            cnt       <= 16'd0;
            shreg     <= 24'd0;
            bit_cnt   <= 5'd0;
            grb       <= 24'd0;
            grbValid  <= 1'b0;
            frameDone <= 1'b0;
            wordCount <= 8'd0;
            error     <= 1'b0;
`ifdef NZR_FORWARD_EN
            fwd       <= 1'b0;
            dataOut   <= 1'b0;
`endif
        end else begin
            sync_meta <= dataIn;
            sync      <= sync_meta;
            sync_d    <= sync;
            grbValid  <= 1'b0;
            frameDone <= 1'b0;
`ifdef NZR_FORWARD_EN
            dataOut   <= fwd ? sync : 1'b0;
`endif
            case (state)
                IDLE: begin
                    if (rise) begin
                        state     <= HIGH;
                        cnt       <= 16'd0;
                        wordCount <= 8'd0;
                        error     <= 1'b0;
                        bit_cnt   <= 5'd0;
                        shreg     <= 24'd0;
`ifdef NZR_FORWARD_EN
                        fwd       <= 1'b0;
`endif
                    end
                end
                HIGH: begin
                    if (fall) begin
                        state <= LOW;
                        cnt   <= 16'd0;
                        shreg <= next_word;
                        if (bit_cnt == 5'd23) begin
                            bit_cnt   <= 5'd0;
                            wordCount <= wc_inc;
`ifdef NZR_FORWARD_EN
                            if (!fwd) begin
                                grb      <= next_word;
                                grbValid <= 1'b1;
                            end
                            fwd <= 1'b1;
`else
                            grb      <= next_word;
                            grbValid <= 1'b1;
`endif
                        end else begin
                            bit_cnt <= bit_cnt + 5'd1;
                        end
                    end else if (cnt == HIGH_LAST) begin
                        error   <= 1'b1;
                        bit_cnt <= 5'd0;
                        cnt     <= 16'd0;
                        state   <= WAIT_GAP;
`ifdef NZR_FORWARD_EN
                        fwd     <= 1'b0;
`endif
                    end else begin
                        cnt <= cnt_inc;
                    end
                end
                LOW: begin
                    if (rise) begin
                        state <= HIGH;
                        cnt   <= 16'd0;
                    end else if (cnt == GAP_LAST) begin
                        frameDone <= 1'b1;
                        bit_cnt   <= 5'd0;
                        cnt       <= 16'd0;
                        state     <= IDLE;
`ifdef NZR_FORWARD_EN
                        fwd       <= 1'b0;
`endif
                    end else begin
                        cnt <= cnt_inc;
                    end
                end
                default: begin
                    // WAIT_GAP: any high sample restarts the low-time measurement
                    if (sync) begin
                        cnt <= 16'd0;
                    end else if (cnt == GAP_LAST) begin
                        cnt   <= 16'd0;
                        state <= IDLE;
                    end else begin
                        cnt <= cnt_inc;
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_nzr_pixel_rx.sv
// Directed bench for nzr_pixel_rx: scoreboarded words, gap/timeout/reset cases.
// Honours NZR_FORWARD_EN for the pixel-mode expectations.
module tb_nzr_pixel_rx;
    localparam int HI1 = 40;
    localparam int LO1 = 22;
    localparam int HI0 = 20;
    localparam int LO0 = 42;
    localparam int GAP = 2600;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        dataIn = 1'b0;
    logic [23:0] grb;
    logic        grbValid;
    logic        frameDone;
    logic [7:0]  wordCount;
    logic        error;
    logic        dataOut;
    logic [1:0]  fsm_state;

    nzr_pixel_rx dut (
        .clk       (clk),
        .reset     (reset),
        .dataIn    (dataIn),
        .grb       (grb),
        .grbValid  (grbValid),
        .frameDone (frameDone),
        .wordCount (wordCount),
        .error     (error),
        .dataOut   (dataOut),
        .fsm_state (fsm_state)
    );

    always #10 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int          compared = 0;
    int          mismatched = 0;
    logic [23:0] exp_q[$];
    int          pushed = 0;
    int          exp_fd = 0;
    int          gv_cnt = 0;
    int          fd_cnt = 0;
    int          fall_cyc = 0;
    int          do_len = 0;
    int          do_bits = 0;
    logic [23:0] do_word = 24'd0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Output monitor: scoreboard pops, latency, pulse exclusivity, dataOut decode.
    always @(negedge clk) begin
        if (reset) begin
            if (grbValid || frameDone)
                check("valid_done_overlap", {31'd0, grbValid & frameDone}, 32'd0);
            if (grbValid) begin
                gv_cnt++;
                if (exp_q.size() == 0) begin
                    check("unexpected_grb_valid", exp_q.size(), 32'd1);
                end else begin
                    check("grb_word", grb, exp_q.pop_front());
                    check("grb_latency", cyc - fall_cyc, 32'd3);
                end
            end
            if (frameDone) fd_cnt++;
            if (dataOut) begin
                do_len++;
            end else if (do_len > 0) begin
                do_word = {do_word[22:0], (do_len >= 30)};
                do_bits++;
                do_len = 0;
            end
        end
    end

    task automatic expect_word(input logic [23:0] w);
        exp_q.push_back(w);
        pushed++;
    endtask

    task automatic send_bit(input int hi, input int lo);
        dataIn = 1'b1;
        repeat (hi) @(negedge clk);
        dataIn = 1'b0;
        fall_cyc = cyc;
        repeat (lo) @(negedge clk);
    endtask

    task automatic send_bits(input logic [23:0] w, input int first, input int last);
        for (int i = first; i >= last; i--) begin
            if (w[i]) send_bit(HI1, LO1);
            else      send_bit(HI0, LO0);
        end
    endtask

    task automatic gap();
        repeat (GAP) @(negedge clk);
    endtask

    initial begin
        logic [23:0] last_grb;
        repeat (3) @(negedge clk);
        check("rst_grb", grb, 32'd0);
        check("rst_grb_valid", grbValid, 32'd0);
        check("rst_frame_done", frameDone, 32'd0);
        check("rst_word_count", wordCount, 32'd0);
        check("rst_error", error, 32'd0);
        check("rst_data_out", dataOut, 32'd0);
        check("rst_state", fsm_state, 32'd3);
        reset = 1'b1;
        gap();
        check("startup_idle", fsm_state, 32'd0);
        check("startup_no_frame_done", fd_cnt, exp_fd);

        // single word then gap
        expect_word(24'hFF0000);
        send_bits(24'hFF0000, 23, 0);
        gap();
        exp_fd++;
        check("w1_valid_count", gv_cnt, pushed);
        check("w1_frame_done", fd_cnt, exp_fd);
        check("w1_grb", grb, 32'hFF0000);
        check("w1_word_count", wordCount, 32'd1);

        // two words in one frame
        expect_word(24'h123456);
`ifndef NZR_FORWARD_EN
        expect_word(24'hABCDEF);
`endif
        send_bits(24'h123456, 23, 0);
        send_bits(24'hABCDEF, 23, 0);
        gap();
        exp_fd++;
        check("w2_valid_count", gv_cnt, pushed);
        check("w2_frame_done", fd_cnt, exp_fd);
        check("w2_word_count", wordCount, 32'd2);
`ifdef NZR_FORWARD_EN
        check("w2_grb", grb, 32'h123456);
        check("w2_fwd_bits", do_bits, 32'd24);
        check("w2_fwd_word", do_word, 32'hABCDEF);
`else
        check("w2_grb", grb, 32'hABCDEF);
`endif
        last_grb = grb;

        // partial word discarded by the gap
        send_bits(24'h5A5A5A, 23, 14);
        gap();
        exp_fd++;
        check("part_valid_count", gv_cnt, pushed);
        check("part_frame_done", fd_cnt, exp_fd);
        check("part_grb_hold", grb, {8'd0, last_grb});
        expect_word(24'h00FF00);
        send_bits(24'h00FF00, 23, 0);
        gap();
        exp_fd++;
        check("after_part_grb", grb, 32'h00FF00);
        check("after_part_word_count", wordCount, 32'd1);

        // threshold: 29 high -> 0, 30 high -> 1, rest are ones
        expect_word(24'h7FFFFF);
        send_bit(29, 62 - 29);
        send_bit(30, 62 - 30);
        for (int i = 21; i >= 0; i--) send_bit(HI1, LO1);
        gap();
        exp_fd++;
        check("thresh_grb", grb, 32'h7FFFFF);
        check("thresh_frame_done", fd_cnt, exp_fd);

        // high timeout
        dataIn = 1'b1;
        repeat (70) @(negedge clk);
        check("timeout_not_yet", error, 32'd0);
        repeat (10) @(negedge clk);
        check("timeout_error", error, 32'd1);
        dataIn = 1'b0;
        gap();
        check("timeout_no_valid", gv_cnt, pushed);
        check("timeout_no_frame_done", fd_cnt, exp_fd);
        check("timeout_sticky", error, 32'd1);
        check("timeout_idle", fsm_state, 32'd0);
        expect_word(24'hA5A5A5);
        send_bits(24'hA5A5A5, 23, 23);
        check("error_cleared", error, 32'd0);
        send_bits(24'hA5A5A5, 22, 0);
        gap();
        exp_fd++;
        check("post_err_grb", grb, 32'hA5A5A5);
        check("post_err_word_count", wordCount, 32'd1);

        // reset in the middle of a word
        send_bits(24'h3C3C3C, 23, 12);
        reset = 1'b0;
        #1;
        check("midrst_grb", grb, 32'd0);
        check("midrst_word_count", wordCount, 32'd0);
        check("midrst_error", error, 32'd0);
        check("midrst_state", fsm_state, 32'd3);
        @(negedge clk);
        reset = 1'b1;
        gap();
        check("midrst_no_valid", gv_cnt, pushed);
        expect_word(24'hC0FFEE);
        send_bits(24'hC0FFEE, 23, 0);
        gap();
        exp_fd++;
        check("midrst_grb_new", grb, 32'hC0FFEE);
        check("midrst_frame_done", fd_cnt, exp_fd);

        check("final_valid_count", gv_cnt, pushed);
        check("final_queue_empty", exp_q.size(), 32'd0);
`ifndef NZR_FORWARD_EN
        check("no_forwarding", do_bits, 32'd0);
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
